// File: rtl/block_average_decimator_pkg.sv
// -----------------------------------------------------------------------------
// block_average_decimator_pkg
// Shared constants and helpers for the block-average decimator.
//   DATA_W       : sample width used on every data port
//   MAX_ACC_W    : accumulator width for the largest legal block (LOG2_LEN=8)
//   acc_width()  : accumulator width for a given block exponent
//   round_shift(): round-half-up arithmetic divide by 2^log2_len
// -----------------------------------------------------------------------------
package block_average_decimator_pkg;

  localparam int DATA_W    = 16;
  localparam int MAX_LOG2  = 8;
  localparam int MAX_ACC_W = 17 + MAX_LOG2;

  function automatic int acc_width(input int log2_len);
    return 17 + log2_len;
  endfunction

  // Adding half an LSB of the result before the arithmetic shift rounds ties
  // toward +inf for both signs (4.5 -> 5, -4.5 -> -4). The mean of 16-bit
  // samples always fits back into 16 bits, so truncation is safe.
  function automatic logic signed [DATA_W-1:0] round_shift(
    input logic signed [MAX_ACC_W-1:0] sum,
    input int                          log2_len
  );
    logic signed [MAX_ACC_W-1:0] rounded;
    rounded = sum + (MAX_ACC_W'(1) <<< (log2_len - 1));
    return DATA_W'(rounded >>> log2_len);
  endfunction

endpackage

// File: rtl/block_average_decimator_extrema.sv
// -----------------------------------------------------------------------------
// block_average_decimator_extrema (block_extrema)
// Running min/max tracker for one block plus the registered block results.
//   i_clk      : system clock
//   i_reset    : async active-high reset, clears everything to 0
//   i_sample   : signed sample being accepted this cycle
//   i_start    : sample is the first of a block (loads running regs)
//   i_update   : sample continues the block (signed compare update)
//   i_complete : sample finishes the block (publish min/max incl. sample)
//   o_min/o_max: min/max of the last completed block, held between blocks
// -----------------------------------------------------------------------------
module block_average_decimator_extrema
  import block_average_decimator_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_start,
  input  logic                     i_update,
  input  logic                     i_complete,
  output logic signed [DATA_W-1:0] o_min,
  output logic signed [DATA_W-1:0] o_max
);

  logic signed [DATA_W-1:0] r_run_min;
  logic signed [DATA_W-1:0] r_run_max;
  logic signed [DATA_W-1:0] r_out_min;
  logic signed [DATA_W-1:0] r_out_max;
  logic signed [DATA_W-1:0] w_next_min;
  logic signed [DATA_W-1:0] w_next_max;

  // Min/max including the current sample; the completing sample must be
  // folded in before publishing, so outputs load from these, not the regs.
  always_comb begin
    w_next_min = r_run_min;
    w_next_max = r_run_max;
    if (i_start) begin
      w_next_min = i_sample;
      w_next_max = i_sample;
    end else if (i_update) begin
      if (i_sample < r_run_min) w_next_min = i_sample;
      if (i_sample > r_run_max) w_next_max = i_sample;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_run_min <= '0;
      r_run_max <= '0;
      r_out_min <= '0;
      r_out_max <= '0;
    end else begin
      if (i_start || i_update) begin
        r_run_min <= w_next_min;
        r_run_max <= w_next_max;
      end
      if (i_complete) begin
        r_out_min <= w_next_min;
        r_out_max <= w_next_max;
      end
    end
  end

  assign o_min = r_out_min;
  assign o_max = r_out_max;

endmodule

// File: rtl/block_average_decimator.sv
// -----------------------------------------------------------------------------
// block_average_decimator
// Averages non-overlapping blocks of 2^LOG2_LEN samples and emits the rounded
// mean with block min/max and a one-cycle valid strobe.
//   i_clk        : system clock (rising edge)
//   i_reset      : async active-high reset
//   i_input      : signed sample from the median stage
//   i_in_valid   : qualifies i_input
//   i_clear      : sync; drops the partial block (and this cycle's sample)
//   o_output     : rounded mean of the last completed block
//   o_out_min    : minimum of the last completed block
//   o_out_max    : maximum of the last completed block
//   o_out_valid  : one-cycle pulse when the three results update
//
// state | meaning (implied by r_cnt, no separate state register)
// IDLE  | r_cnt == 0, no partial block; next accepted sample starts a block
// ACCUM | 0 < r_cnt < N, block in progress
// -----------------------------------------------------------------------------
module block_average_decimator
  import block_average_decimator_pkg::*;
#(
  parameter int LOG2_LEN = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic signed [DATA_W-1:0] i_input,
  input  logic                     i_in_valid,
  input  logic                     i_clear,
  output logic signed [DATA_W-1:0] o_output,
  output logic signed [DATA_W-1:0] o_out_min,
  output logic signed [DATA_W-1:0] o_out_max,
  output logic                     o_out_valid
);

  localparam int                  ACC_W    = acc_width(LOG2_LEN);
  localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;

  logic        [LOG2_LEN-1:0]  r_cnt;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [DATA_W-1:0]    r_output;
  logic                        r_out_valid;

  logic                        w_accept;
  logic                        w_start;
  logic                        w_update;
  logic                        w_complete;
  logic signed [ACC_W-1:0]     w_sample_ext;
  logic signed [ACC_W-1:0]     w_full_sum;
  logic signed [MAX_ACC_W-1:0] w_sum_ext;

  // Clear dominates: a sample arriving with Clear is not accepted at all.
  assign w_accept   = i_in_valid && !i_clear;
  assign w_start    = w_accept && (r_cnt == '0);
  assign w_update   = w_accept && (r_cnt != '0);
  assign w_complete = w_accept && (r_cnt == CNT_LAST);

  assign w_sample_ext = ACC_W'(i_input);
  assign w_full_sum   = r_acc + w_sample_ext;
  assign w_sum_ext    = MAX_ACC_W'(w_full_sum);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_output    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_complete;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        // Counter is exactly LOG2_LEN bits, so it wraps to 0 after sample N.
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_start ? w_sample_ext : w_full_sum;
      end
      if (w_complete) begin
        r_output <= round_shift(w_sum_ext, LOG2_LEN);
      end
    end
  end

  block_average_decimator_extrema u_extrema (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sample   (i_input),
    .i_start    (w_start),
    .i_update   (w_update),
    .i_complete (w_complete),
    .o_min      (o_out_min),
    .o_max      (o_out_max)
  );

  assign o_output    = r_output;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_block_average_decimator.sv
module tb_block_average_decimator;

  logic               clk = 1'b0;
  logic               clk_run = 1'b1;
  logic               reset = 1'b0;
  logic signed [15:0] din = '0;
  logic               din_valid = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] dout;
  logic signed [15:0] dmin;
  logic signed [15:0] dmax;
  logic               dvalid;

  int total = 0;
  int bad   = 0;

  block_average_decimator #(.LOG2_LEN(3)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_input     (din),
    .i_in_valid  (din_valid),
    .i_clear     (clear),
    .o_output    (dout),
    .o_out_min   (dmin),
    .o_out_max   (dmax),
    .o_out_valid (dvalid)
  );

  // Clock can be frozen low to exercise the asynchronous reset path.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, pass the rising edge, sample 1 time unit later.
  task automatic step(input int v, input logic vld, input logic clr);
    din       = 16'(v);
    din_valid = vld;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  // Feed 8 valid samples v0, v0+inc, ...; the strobe must appear only after
  // the 8th and its results must match the hand-computed values.
  task automatic feed_block(input string tag, input int v0, input int inc,
                            input int exp_out, input int exp_min, input int exp_max);
    for (int i = 0; i < 8; i++) begin
      step(v0 + i * inc, 1'b1, 1'b0);
      check_val({tag, "_valid"}, int'(dvalid), (i == 7) ? 1 : 0);
    end
    check_val({tag, "_out"}, int'(dout), exp_out);
    check_val({tag, "_min"}, int'(dmin), exp_min);
    check_val({tag, "_max"}, int'(dmax), exp_max);
  endtask

  initial begin
    reset = 1'b1;
    #12;
    check_val("rst_out",   int'(dout),   0);
    check_val("rst_min",   int'(dmin),   0);
    check_val("rst_max",   int'(dmax),   0);
    check_val("rst_valid", int'(dvalid), 0);
    @(negedge clk);
    reset = 1'b0;

    // Ramp 1..8: 36/8 = 4.5 -> 5
    feed_block("ramp", 1, 1, 5, 1, 8);
    step(0, 1'b0, 1'b0);
    check_val("ramp_pulse_one_cycle", int'(dvalid), 0);
    check_val("ramp_hold", int'(dout), 5);

    // -1..-8: -36/8 = -4.5 -> -4
    feed_block("neg", -1, -1, -4, -8, -1);

    // Back-to-back extremes with InValid held high: pulses every 8 cycles.
    feed_block("maxpos", 32767, 0, 32767, 32767, 32767);
    feed_block("maxneg", -32768, 0, -32768, -32768, -32768);

    // Gapped valid: block stretches, pulse one cycle after 8th valid sample.
    for (int i = 0; i < 8; i++) begin
      step(100, 1'b1, 1'b0);
      check_val("gap_valid", int'(dvalid), (i == 7) ? 1 : 0);
      step(55, 1'b0, 1'b0);
      check_val("gap_idle", int'(dvalid), 0);
    end
    check_val("gap_out", int'(dout), 100);
    check_val("gap_min", int'(dmin), 100);
    check_val("gap_max", int'(dmax), 100);

    // Clear collides with what would be the completing sample.
    for (int i = 0; i < 7; i++) begin
      step(10, 1'b1, 1'b0);
      check_val("clr_pre_valid", int'(dvalid), 0);
    end
    step(10, 1'b1, 1'b1);
    check_val("clr_coll_valid", int'(dvalid), 0);
    check_val("clr_hold_out", int'(dout), 100);
    feed_block("clr_next", 20, 0, 20, 20, 20);

    // Async reset mid-block with the clock stopped.
    for (int i = 0; i < 5; i++) step(7, 1'b1, 1'b0);
    din_valid = 1'b0;
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_out",   int'(dout),   0);
    check_val("arst_min",   int'(dmin),   0);
    check_val("arst_max",   int'(dmax),   0);
    check_val("arst_valid", int'(dvalid), 0);
    #2;
    reset = 1'b0;
    #1;
    clk_run = 1'b1;
    feed_block("arst_next", 3, 0, 3, 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the bench should never get near this.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/block_average_decimator.md
# block_average_decimator

Downstream consumer of the moving-median stage. It accumulates non-overlapping blocks of 2^LOG2_LEN median samples and emits one rounded block mean per block, together with the block minimum and maximum and a one-cycle valid strobe. Its output is the decimated, de-spiked measurement stream handed to the instrument output and readback logic.

## Interface
- LOG2_LEN, default 3: block length exponent; N = 2^LOG2_LEN samples per block; legal range 1..8.
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs.
- Input  in  16  signed sample from the median stage.
- InValid  in  1  qualifies Input; tie high for one sample per clock.
- Clear  in  1  synchronous; discards the partial block and restarts counting.
- Output  out  16  signed rounded mean of the last completed block.
- OutMin  out  16  signed minimum of the last completed block.
- OutMax  out  16  signed maximum of the last completed block.
- OutValid  out  1  one-cycle pulse when Output, OutMin and OutMax update.

## Operation
- Internal state:
  - sample counter cnt, LOG2_LEN bits;
  - accumulator acc, signed 17+LOG2_LEN bits;
  - running min and max registers run_min and run_max.
- States: IDLE (cnt=0, no partial block) and ACCUM (0<cnt<N). The state is implied by cnt; no separate state register.
- Accepted sample (InValid=1, Clear=0):
  - If cnt=0: acc<=Input, run_min<=Input, run_max<=Input.
  - Else: acc<=acc+Input; run_min and run_max updated by signed compare.
  - cnt increments and wraps to 0 after the Nth sample.
- Block completion (accepted sample with cnt=N-1):
  - full_sum = acc+Input.
  - Output <= (full_sum + 2^(LOG2_LEN-1)) >>> LOG2_LEN, arithmetic shift (round half up).
  - Result always fits 16 bits; no saturation logic.
  - OutMin and OutMax include the completing sample.
  - OutValid<=1. The next accepted sample starts a fresh block.
- InValid=0: no state change; OutValid=0.
- Clear=1:
  - cnt<=0; the partial block is discarded, including any sample presented in the same cycle.
  - Output, OutMin and OutMax hold their last values; OutValid<=0.
- Outputs hold between strobes.

## Timing
- Reset values: cnt=0, acc=0, run_min=0, run_max=0, Output=0, OutMin=0, OutMax=0, OutValid=0.
- Reset mid-block discards the partial block. The first accepted sample after deassertion is sample 0 of a new block.
- Latency: OutValid rises on the clock edge that registers the Nth accepted sample, i.e. visible one cycle after that sample is presented.
- Throughput: with InValid held high, exactly one OutValid pulse every N cycles, and never two consecutive pulses (N≥2).
- Gaps in InValid stretch the block and do not restart it.
- Clear and a completing sample in the same cycle: Clear wins, and no OutValid is issued.
- Downstream logic must capture on OutValid; there is no backpressure.

## Structure
- Shared package holds:
  - DATA_W=16;
  - a function acc_width(log2_len) returning 17+log2_len;
  - a function round_shift(sum, log2_len) implementing the round-half-up arithmetic shift.
- Sub-module block_extrema holds run_min and run_max with start/update/complete controls. The accumulator and counter live in the top module.

## Test plan
- Reset and ramp:
  - Stimulus: LOG2_LEN=3, InValid=1, Input = 1,2,…,8.
  - Response: one OutValid pulse; Output=5 (36/8=4.5, rounded up); OutMin=1; OutMax=8.
- Negative rounding:
  - Stimulus: Input = -1,-2,…,-8.
  - Response: Output=-4 (-4.5 rounds toward +inf); OutMin=-8; OutMax=-1.
- Extremes:
  - Stimulus: 8×32767, then 8×(-32768).
  - Response: Output=32767, then Output=-32768; no wrap.
- Gapped valid:
  - Stimulus: 8 samples of value 100 interleaved with InValid=0 cycles.
  - Response: exactly one pulse, Output=100, issued one cycle after the 8th valid sample.
- Clear collision:
  - Stimulus: 7 samples of 10, then Clear=1 with an 8th sample of 10, then 8 samples of 20.
  - Response: no pulse for the first block; next pulse has Output=20 and OutMin=OutMax=20.
- Async reset mid-block:
  - Stimulus: Reset asserted after 5 samples while Clk is stopped.
  - Response: all outputs read 0 immediately; after release, a block of 8×3 gives Output=3.
